queue_xfer_ctrl: RTL and testbench

// Single-clock scheduler between the serial deserializer and the byte queue in top.

---
 rtl/queue_xfer_ctrl.sv | 148 ++++++++++++++
 tb/tb_queue_xfer_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/queue_xfer_ctrl.sv
// Scheduler between the deserializer and the byte queue: arbitrates the single queue
// access slot between enqueues and dequeues, back-pressures writes and counts drops.
module queue_xfer_ctrl #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned BURST_TH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             cons_req_in,
    input  logic             burst_en_in,
    output logic             enqueue_out,
    output logic             dequeue_out,
    output logic             cons_vld_out,
    output logic             status_out,
    output logic             busy_out,
    output logic [7:0]       drop_cnt_out
);

    localparam int unsigned CW = LEN_W + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DepthC     = CW'(DEPTH);
    localparam logic [CW-1:0] BurstC     = CW'(BURST_TH);
    localparam logic [SW-1:0] StarveMaxC = SW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StEnq, StDeq, StSettle} state_e;

    state_e        state_q, state_d;
    logic          pending_q, pending_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          burst_q, burst_d;
    logic          cons_deq_q, cons_deq_d;
    logic          enq_q, enq_d;
    logic          deq_q, deq_d;
    logic          cons_vld_q, cons_vld_d;
    logic          status_q, status_d;
    logic [7:0]    drop_q, drop_d;

    logic [CW-1:0] len_ext;
    logic          full, len_nz, burst_hit;
    logic          enq_req, deq_req, grant_enq, grant_deq;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;

    // Occupancy compares are done one bit wider than the bus so nothing wraps.
    assign len_ext   = {1'b0, len_in};
    assign full      = len_ext >= DepthC;
    assign len_nz    = len_in != '0;
    assign burst_hit = len_ext >= BurstC;

    // A write arriving this cycle already counts as pending for arbitration.
    assign enq_req = pending_q | write_in;
    assign deq_req = (cons_req_in | burst_q) & len_nz;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | write_in;
        starve_d   = starve_q;
        burst_d    = burst_q;
        cons_deq_d = cons_deq_q;
        enq_d      = 1'b0;
        deq_d      = 1'b0;
        cons_vld_d = 1'b0;
        grant_enq  = 1'b0;
        grant_deq  = 1'b0;
        drop_inc   = (write_in && pending_q) ? 2'd1 : 2'd0;

        case (state_q)
            StIdle: begin
                if (burst_en_in && burst_hit) begin
                    burst_d = 1'b1;
                end
                grant_deq = deq_req && (!enq_req || full || starve_q == StarveMaxC);
                grant_enq = enq_req && !full && !grant_deq;
                if (enq_req && full) begin
                    drop_inc  = drop_inc + 2'd1;
                    pending_d = 1'b0;
                end
                if (grant_enq) begin
                    state_d   = StEnq;
                    enq_d     = 1'b1;
                    pending_d = 1'b0;
                    if (deq_req && starve_q < StarveMaxC) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (grant_deq) begin
                    state_d    = StDeq;
                    deq_d      = 1'b1;
                    starve_d   = '0;
                    cons_deq_d = cons_req_in;
                end
            end
            StEnq:    state_d = StSettle;
            StDeq: begin
                state_d    = StSettle;
                // Burst-only drains never hand a byte to the consumer.
                cons_vld_d = cons_deq_q;
            end
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (!burst_en_in || !len_nz) begin
            burst_d = 1'b0;
        end

        drop_sum = {1'b0, drop_q} + 9'(drop_inc);
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        status_d = (len_ext + CW'(pending_q) + CW'(enq_q)) < DepthC;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            starve_q   <= '0;
            burst_q    <= 1'b0;
            cons_deq_q <= 1'b0;
            enq_q      <= 1'b0;
            deq_q      <= 1'b0;
            cons_vld_q <= 1'b0;
            status_q   <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            cons_deq_q <= cons_deq_d;
            enq_q      <= enq_d;
            deq_q      <= deq_d;
            cons_vld_q <= cons_vld_d;
            status_q   <= status_d;
            drop_q     <= drop_d;
        end
    end

    assign enqueue_out  = enq_q;
    assign dequeue_out  = deq_q;
    assign cons_vld_out = cons_vld_q;
    assign status_out   = status_q;
    assign drop_cnt_out = drop_q;
    assign busy_out     = reset & ((state_q != StIdle) | pending_q | write_in);

endmodule

// File: tb/tb_queue_xfer_ctrl.sv
// Directed bench for queue_xfer_ctrl: reset, enqueue/dequeue latency, full drops,
// starvation limit and burst drain, with the queue occupancy driven by the bench.
`timescale 1ns/1ps
module tb_queue_xfer_ctrl;

    logic       clock       = 1'b0;
    logic       reset       = 1'b0;
    logic       write_in    = 1'b0;
    logic [3:0] len_in      = 4'd0;
    logic       cons_req_in = 1'b0;
    logic       burst_en_in = 1'b0;
    logic       enqueue_out, dequeue_out, cons_vld_out, status_out, busy_out;
    logic [7:0] drop_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    int e_cnt;
    int d_cnt;
    int vld_seen;

    always #500 clock = ~clock;

    queue_xfer_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .write_in     (write_in),
        .len_in       (len_in),
        .cons_req_in  (cons_req_in),
        .burst_en_in  (burst_en_in),
        .enqueue_out  (enqueue_out),
        .dequeue_out  (dequeue_out),
        .cons_vld_out (cons_vld_out),
        .status_out   (status_out),
        .busy_out     (busy_out),
        .drop_cnt_out (drop_cnt_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset
        tick();
        tick();
        check("rst_enq", 32'(enqueue_out), 32'd0);
        check("rst_deq", 32'(dequeue_out), 32'd0);
        check("rst_vld", 32'(cons_vld_out), 32'd0);
        check("rst_status", 32'(status_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_drop", 32'(drop_cnt_out), 32'd0);
        reset = 1'b1;
        tick();
        check("status_after_rst", 32'(status_out), 32'd1);

        // 2: single write into an empty queue
        write_in = 1'b1;
        #1;
        check("wr_busy0", 32'(busy_out), 32'd1);
        tick();
        check("enq_pulse", 32'(enqueue_out), 32'd1);
        check("wr_busy1", 32'(busy_out), 32'd1);
        write_in = 1'b0;
        tick();
        check("enq_off", 32'(enqueue_out), 32'd0);
        check("wr_busy2", 32'(busy_out), 32'd1);
        tick();
        check("wr_busy_end", 32'(busy_out), 32'd0);

        // 3: consumer dequeue
        len_in      = 4'd3;
        cons_req_in = 1'b1;
        tick();
        check("deq_pulse", 32'(dequeue_out), 32'd1);
        check("deq_vld_early", 32'(cons_vld_out), 32'd0);
        cons_req_in = 1'b0;
        tick();
        check("deq_off", 32'(dequeue_out), 32'd0);
        check("cons_vld", 32'(cons_vld_out), 32'd1);
        tick();
        check("cons_vld_off", 32'(cons_vld_out), 32'd0);
        check("deq_idle", 32'(busy_out), 32'd0);

        // 4: writes into a full queue are dropped
        len_in   = 4'd8;
        write_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_enq", 32'(enqueue_out), 32'd0);
        end
        write_in = 1'b0;
        tick();
        check("full_drop3", 32'(drop_cnt_out), 32'd3);
        check("full_status", 32'(status_out), 32'd0);
        write_in    = 1'b1;
        cons_req_in = 1'b1;
        tick();
        check("full_deq", 32'(dequeue_out), 32'd1);
        check("full_drop4", 32'(drop_cnt_out), 32'd4);
        write_in    = 1'b0;
        cons_req_in = 1'b0;
        tick();
        tick();
        write_in = 1'b1;
        repeat (260) tick();
        write_in = 1'b0;
        tick();
        check("drop_saturate", 32'(drop_cnt_out), 32'd255);

        // 5: starvation limit
        reset = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
        len_in = 4'd2;
        tick();
        check("drop_cleared", 32'(drop_cnt_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            write_in    = 1'b1;
            cons_req_in = 1'b1;
            tick();
            write_in = 1'b0;
            if (k < 3) begin
                check("starve_enq", 32'(enqueue_out), 32'd1);
                check("starve_no_deq", 32'(dequeue_out), 32'd0);
            end else begin
                check("starve_deq", 32'(dequeue_out), 32'd1);
                check("starve_no_enq", 32'(enqueue_out), 32'd0);
            end
            tick();
            if (k == 3) check("starve_vld", 32'(cons_vld_out), 32'd1);
            tick();
        end
        cons_req_in = 1'b0;
        e_cnt = 0;
        d_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            e_cnt += int'(enqueue_out);
            d_cnt += int'(dequeue_out);
        end
        check("late_enq", e_cnt, 1);
        check("late_no_deq", d_cnt, 0);
        check("starve_no_drop", 32'(drop_cnt_out), 32'd0);
        check("starve_idle", 32'(busy_out), 32'd0);

        // 6: burst drain, then reset mid-drain
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        burst_en_in = 1'b1;
        len_in      = 4'd4;
        pulses      = 0;
        vld_seen    = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cons_vld_out) vld_seen = 1;
            if (dequeue_out) begin
                pulses++;
                len_in = len_in - 4'd1;
            end
        end
        check("burst_pulses", pulses, 4);
        check("burst_no_vld", vld_seen, 0);
        check("burst_idle", 32'(busy_out), 32'd0);

        len_in = 4'd5;
        pulses = 0;
        for (int i = 0; i < 30 && pulses < 2; i++) begin
            tick();
            if (dequeue_out) begin
                pulses++;
                len_in = len_in - 4'd1;
            end
        end
        check("burst_mid", pulses, 2);
        reset = 1'b0;
        tick();
        check("rst_mid_deq", 32'(dequeue_out), 32'd0);
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dequeue_out) pulses++;
        end
        check("burst_stopped", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
